fpu_lsh_norm: RTL

FPU_LSH_NORM -- requirements
Module: fpu_lsh_norm

---
 rtl/fpu_lsh_norm.sv | 116 +++++++++++
 1 files changed

// File: rtl/fpu_lsh_norm.sv
// Iterative left normalizer for FPU mantissas.
// Shifts up to 8 bits per cycle, bounded by the exponent budget.
module fpu_lsh_norm #(
    parameter int WIDTH  = 32,
    parameter int EWIDTH = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_mant,
    input  logic [EWIDTH-1:0]          in_exp,
    input  logic                       in_sticky,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_mant,
    output logic [EWIDTH-1:0]          out_exp,
    output logic [$clog2(WIDTH):0]     out_lsh,
    output logic                       out_zero,
    output logic                       out_sticky
);

    localparam int LW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mant;
    logic [EWIDTH-1:0] exp;
    logic [LW-1:0]     lsh;
    logic              zero;
    logic              sticky;

    logic [3:0]        lz;
    logic [EWIDTH-1:0] budget;
    logic [3:0]        s;
    logic [WIDTH-1:0]  mant_nx;
    logic [EWIDTH-1:0] exp_nx;
    logic [LW-1:0]     lsh_nx;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_mant   = mant;
    assign out_exp    = exp;
    assign out_lsh    = lsh;
    assign out_zero   = zero;
    assign out_sticky = sticky;

    // Leading zeros of the top byte; the highest set bit wins.
    always_comb begin
        lz = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (mant[WIDTH-8+i]) lz = 4'(7 - i);
        end
    end

    // Step size clamped so the exponent never drops below 1.
    always_comb begin
        budget  = (exp > EWIDTH'(1)) ? exp - EWIDTH'(1) : '0;
        s       = (EWIDTH'(lz) < budget) ? lz : budget[3:0];
        mant_nx = mant << s;
        exp_nx  = exp - EWIDTH'(s);
        lsh_nx  = lsh + LW'(s);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mant   <= '0;
            exp    <= '0;
            lsh    <= '0;
            zero   <= 1'b0;
            sticky <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sticky <= in_sticky;
                        lsh    <= '0;
                        if (in_mant == '0) begin
                            zero  <= 1'b1;
                            mant  <= '0;
                            exp   <= '0;
                            state <= DONE;
                        end else begin
                            zero  <= 1'b0;
                            mant  <= in_mant;
                            exp   <= in_exp;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mant <= mant_nx;
                    lsh  <= lsh_nx;
                    if (s == 4'd8) begin
                        exp <= exp_nx;
                    end else begin
                        exp   <= mant_nx[WIDTH-1] ? exp_nx : '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
